// File: rtl/deck_receiver_pkg.sv
// Shared definitions for the deck receiver: FSM encoding, deck geometry and
// the card/rank/suit/value field widths.
package deck_receiver_pkg;

    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned SUIT_SIZE = 13;
    localparam int unsigned CARD_W    = 6;
    localparam int unsigned RANK_W    = 4;
    localparam int unsigned SUIT_W    = 2;
    localparam int unsigned VALUE_W   = 4;

    typedef enum logic [1:0] {
        SHUF  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        ERR   = 2'd3
    } state_t;

    // Decoded attributes of one card.
    typedef struct packed {
        logic [RANK_W-1:0]  rank;
        logic [SUIT_W-1:0]  suit;
        logic [VALUE_W-1:0] value;
    } card_info_t;

endpackage

// File: rtl/deck_receiver_if.sv
// Deck receiver bus: shuffler load side, dealer request side and status.
//   master: environment (drives load_flag, card_in, deal_req)
//   slave : deck_receiver (drives shuffle request, dealt card and status)
interface deck_receiver_if;
    import deck_receiver_pkg::*;

    logic                load_flag;
    logic [CARD_W-1:0]   card_in;
    logic                shuffle_flag;
    logic                deal_req;
    logic                deal_valid;
    logic [CARD_W-1:0]   deal_card;
    logic [RANK_W-1:0]   deal_rank;
    logic [SUIT_W-1:0]   deal_suit;
    logic [VALUE_W-1:0]  deal_value;
    logic                deck_ready;
    logic [CARD_W-1:0]   cards_left;
    logic                low_deck;
    logic                deal_err;
    logic                load_err;

    modport master (
        output load_flag, card_in, deal_req,
        input  shuffle_flag, deal_valid, deal_card, deal_rank, deal_suit,
               deal_value, deck_ready, cards_left, low_deck, deal_err, load_err
    );

    modport slave (
        input  load_flag, card_in, deal_req,
        output shuffle_flag, deal_valid, deal_card, deal_rank, deal_suit,
               deal_value, deck_ready, cards_left, low_deck, deal_err, load_err
    );

endinterface

// File: rtl/deck_receiver_card_decode.sv
// Combinational card decode: rank (1..13), suit (0..3) and blackjack value.
//   card   : card index 0..51
//   info_c : decoded rank/suit/value
module card_decode
    import deck_receiver_pkg::*;
(
    input  logic [CARD_W-1:0] card,
    output card_info_t        info_c
);

    logic [CARD_W-1:0] rem_c;
    logic [RANK_W-1:0] rank_c;

    // Suit by threshold compare, remainder gives the rank within the suit.
    always_comb begin
        info_c = '0;
        rem_c  = card;
        if (card >= CARD_W'(3 * SUIT_SIZE)) begin
            info_c.suit = SUIT_W'(3);
            rem_c       = card - CARD_W'(3 * SUIT_SIZE);
        end else if (card >= CARD_W'(2 * SUIT_SIZE)) begin
            info_c.suit = SUIT_W'(2);
            rem_c       = card - CARD_W'(2 * SUIT_SIZE);
        end else if (card >= CARD_W'(SUIT_SIZE)) begin
            info_c.suit = SUIT_W'(1);
            rem_c       = card - CARD_W'(SUIT_SIZE);
        end
        rank_c       = RANK_W'(rem_c) + RANK_W'(1);
        info_c.rank  = rank_c;
        info_c.value = (rank_c > RANK_W'(10)) ? VALUE_W'(10) : VALUE_W'(rank_c);
    end

endmodule

// File: rtl/deck_receiver.sv
// Deck receiver: captures a shuffled deck from the slotted load interface,
// checks it is a permutation, then deals cards one per request.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : deck_receiver_if.slave (load, deal and status signals)
module deck_receiver #(
    parameter int unsigned DECK_SIZE    = deck_receiver_pkg::DECK_SIZE,
    parameter int unsigned SLOT_CYCLES  = 4,
    parameter int unsigned SAMPLE_PHASE = 2,
    parameter int unsigned LOW_WATER    = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    deck_receiver_if.slave bus
);
    import deck_receiver_pkg::*;

    localparam int unsigned IDX_W     = $clog2(DECK_SIZE);
    localparam int unsigned SLOT_W    = $clog2(DECK_SIZE + 1);
    localparam int unsigned PH_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    // The LOAD entry edge is cycle 0, so the first LOAD edge is cycle 1.
    localparam int unsigned PH_INIT   = 1 % SLOT_CYCLES;
    localparam int unsigned SLOT_INIT = 1 / SLOT_CYCLES;

    state_t               state, state_nxt;
    logic [PH_W-1:0]      phase;
    logic [SLOT_W-1:0]    slot;
    logic [DECK_SIZE-1:0] seen;
    logic [IDX_W-1:0]     rd_ptr;
    logic [CARD_W-1:0]    deck_ram [DECK_SIZE];
    logic [CARD_W-1:0]    rd_card_c;
    card_info_t           rd_info_c;

    logic sample_c, bad_card_c, last_card_c, deal_ok_c, deal_bad_c;
    logic shuffle_nxt, ready_nxt, low_nxt;
    logic [CARD_W-1:0] cards_left_nxt;

    logic              shuffle_q, ready_q, low_q, valid_q, deal_err_q, load_err_q;
    logic [CARD_W-1:0] cards_left_q, card_q;
    card_info_t        info_q;

    assign rd_card_c = deck_ram[rd_ptr];

    card_decode u_card_decode (
        .card   (rd_card_c),
        .info_c (rd_info_c)
    );

    // Sample strobe, card validity and deal qualification.
    always_comb begin
        sample_c    = (state == LOAD) && (phase == PH_W'(SAMPLE_PHASE)) && (slot != '0);
        bad_card_c  = (bus.card_in >= CARD_W'(DECK_SIZE)) || seen[IDX_W'(bus.card_in)];
        last_card_c = (slot == SLOT_W'(DECK_SIZE));
        deal_ok_c   = bus.deal_req && (state == READY) && (cards_left_q != '0);
        deal_bad_c  = bus.deal_req && !deal_ok_c;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SHUF;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            SHUF:    if (bus.load_flag) state_nxt = LOAD;
            LOAD: begin
                if (sample_c) begin
                    if (bad_card_c)       state_nxt = ERR;
                    else if (last_card_c) state_nxt = READY;
                end
            end
            READY:   if (deal_ok_c && (cards_left_q == CARD_W'(1))) state_nxt = SHUF;
            ERR:     state_nxt = ERR;
            default: state_nxt = SHUF;
        endcase
    end

    // Output logic: next values of the registered status outputs.
    always_comb begin
        cards_left_nxt = cards_left_q;
        if (sample_c && !bad_card_c && last_card_c) cards_left_nxt = CARD_W'(DECK_SIZE);
        else if (deal_ok_c)                         cards_left_nxt = cards_left_q - CARD_W'(1);
        shuffle_nxt = (state_nxt == SHUF);
        ready_nxt   = (state_nxt == READY);
        low_nxt     = ready_nxt && (cards_left_nxt <= CARD_W'(LOW_WATER));
    end

    // Load counters, seen bitmap, deal pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= '0;
            slot         <= '0;
            seen         <= '0;
            rd_ptr       <= '0;
            cards_left_q <= '0;
            shuffle_q    <= 1'b1;
            ready_q      <= 1'b0;
            low_q        <= 1'b0;
            valid_q      <= 1'b0;
            deal_err_q   <= 1'b0;
            load_err_q   <= 1'b0;
            card_q       <= '0;
            info_q       <= '0;
        end else begin
            cards_left_q <= cards_left_nxt;
            shuffle_q    <= shuffle_nxt;
            ready_q      <= ready_nxt;
            low_q        <= low_nxt;
            valid_q      <= deal_ok_c;
            deal_err_q   <= deal_bad_c;

            if ((state == SHUF) && bus.load_flag) begin
                phase <= PH_W'(PH_INIT);
                slot  <= SLOT_W'(SLOT_INIT);
                seen  <= '0;
            end else if (state == LOAD) begin
                if (phase == PH_W'(SLOT_CYCLES - 1)) begin
                    phase <= '0;
                    slot  <= slot + SLOT_W'(1);
                end else begin
                    phase <= phase + PH_W'(1);
                end
                if (sample_c) begin
                    if (bad_card_c) load_err_q <= 1'b1;
                    else            seen[IDX_W'(bus.card_in)] <= 1'b1;
                end
            end

            if (sample_c && !bad_card_c && last_card_c) begin
                rd_ptr <= '0;
            end else if (deal_ok_c) begin
                rd_ptr <= rd_ptr + IDX_W'(1);
                card_q <= rd_card_c;
                info_q <= rd_info_c;
            end
        end
    end

    // Deck storage; contents are only meaningful after a complete load.
    always_ff @(posedge clk) begin
        if (sample_c && !bad_card_c) deck_ram[IDX_W'(slot - SLOT_W'(1))] <= bus.card_in;
    end

    assign bus.shuffle_flag = shuffle_q;
    assign bus.deck_ready   = ready_q;
    assign bus.cards_left   = cards_left_q;
    assign bus.low_deck     = low_q;
    assign bus.deal_valid   = valid_q;
    assign bus.deal_err     = deal_err_q;
    assign bus.load_err     = load_err_q;
    assign bus.deal_card    = card_q;
    assign bus.deal_rank    = info_q.rank;
    assign bus.deal_suit    = info_q.suit;
    assign bus.deal_value   = info_q.value;

endmodule

// File: tb/tb_deck_receiver.sv
// Self-checking bench for deck_receiver: hand-written load/exhaust/error
// sequences, a decode vector table and randomized dealing against a
// queue-based deck model.
module tb_deck_receiver;

    logic clk = 1'b0;
    logic rst_n;

    deck_receiver_if bus ();

    deck_receiver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int perm [52];
    int mdl_q [$];
    int mdl_last = 0;

    typedef struct {
        int card;
        int rank;
        int suit;
        int value;
    } dec_vec_t;
    dec_vec_t dec_tab [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_shuffle"},    32'(bus.shuffle_flag), 1);
        check({tag, "_valid"},      32'(bus.deal_valid), 0);
        check({tag, "_card"},       32'(bus.deal_card), 0);
        check({tag, "_rank"},       32'(bus.deal_rank), 0);
        check({tag, "_suit"},       32'(bus.deal_suit), 0);
        check({tag, "_value"},      32'(bus.deal_value), 0);
        check({tag, "_ready"},      32'(bus.deck_ready), 0);
        check({tag, "_cards_left"}, 32'(bus.cards_left), 0);
        check({tag, "_low"},        32'(bus.low_deck), 0);
        check({tag, "_deal_err"},   32'(bus.deal_err), 0);
        check({tag, "_load_err"},   32'(bus.load_err), 0);
    endtask

    // Called just after an edge: asserts reset asynchronously, checks, releases.
    task automatic do_reset(input string tag);
        bus.load_flag = 1'b0;
        bus.deal_req  = 1'b0;
        bus.card_in   = 6'd0;
        rst_n = 1'b0;
        #1;
        check_reset(tag);
        tick();
        rst_n = 1'b1;
        mdl_last = 0;
        mdl_q.delete();
    endtask

    task automatic start_load();
        bus.load_flag = 1'b1;
        bus.card_in   = 6'd0;
    endtask

    // Runs load edges from..to; after edge c, drives the card of the slot
    // containing cycle c+1 (slot k carries perm[k-1]).
    task automatic load_edges(input int from, input int to, input bit poke);
        int s;
        for (int c = from; c <= to; c++) begin
            tick();
            if (poke && c == 100) begin
                check("load_deal_err", 32'(bus.deal_err), 1);
                check("load_deal_valid", 32'(bus.deal_valid), 0);
            end
            bus.deal_req = poke && (c == 99);
            if (c == 20) bus.load_flag = 1'b0;
            s = (c + 1) / 4;
            if (s >= 1 && s <= 52) bus.card_in = 6'(perm[s - 1]);
            else                   bus.card_in = 6'd0;
        end
    endtask

    task automatic full_load(input string tag, input bit poke);
        start_load();
        load_edges(0, 209, poke);
        check({tag, "_ready_209"},   32'(bus.deck_ready), 0);
        check({tag, "_shuffle_209"}, 32'(bus.shuffle_flag), 0);
        load_edges(210, 210, 1'b0);
        check({tag, "_ready_210"},   32'(bus.deck_ready), 1);
        check({tag, "_left_210"},    32'(bus.cards_left), 52);
        check({tag, "_shuffle_210"}, 32'(bus.shuffle_flag), 0);
        check({tag, "_low_210"},     32'(bus.low_deck), 0);
        mdl_q.delete();
        for (int i = 0; i < 52; i++) mdl_q.push_back(perm[i]);
    endtask

    task automatic shuffle_perm();
        int j, t;
        for (int i = 0; i < 52; i++) perm[i] = i;
        for (int i = 51; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
    endtask

    // Random deal requests checked against the deck queue model.
    task automatic random_deal(input int round);
        int  idle = 0;
        int  rank;
        int  sz;
        bit  req, exp_valid;
        for (int cyc = 0; cyc < 400 && idle < 8; cyc++) begin
            req = ($urandom_range(9, 0) < 6);
            bus.deal_req = req;
            tick();
            exp_valid = req && (mdl_q.size() > 0);
            if (exp_valid) mdl_last = mdl_q.pop_front();
            sz   = mdl_q.size();
            rank = (mdl_last % 13) + 1;
            check($sformatf("r%0d_c%0d_valid", round, cyc), 32'(bus.deal_valid), 32'(exp_valid));
            check($sformatf("r%0d_c%0d_err", round, cyc), 32'(bus.deal_err), 32'(req && !exp_valid));
            check($sformatf("r%0d_c%0d_card", round, cyc), 32'(bus.deal_card), mdl_last);
            check($sformatf("r%0d_c%0d_rank", round, cyc), 32'(bus.deal_rank), rank);
            check($sformatf("r%0d_c%0d_suit", round, cyc), 32'(bus.deal_suit), mdl_last / 13);
            check($sformatf("r%0d_c%0d_value", round, cyc), 32'(bus.deal_value), (rank > 10) ? 10 : rank);
            check($sformatf("r%0d_c%0d_left", round, cyc), 32'(bus.cards_left), sz);
            check($sformatf("r%0d_c%0d_ready", round, cyc), 32'(bus.deck_ready), 32'(sz > 0));
            check($sformatf("r%0d_c%0d_low", round, cyc), 32'(bus.low_deck), 32'(sz > 0 && sz <= 15));
            check($sformatf("r%0d_c%0d_shuffle", round, cyc), 32'(bus.shuffle_flag), 32'(sz == 0));
            if (sz == 0) idle++;
        end
        bus.deal_req = 1'b0;
        check($sformatf("r%0d_deal_budget", round), mdl_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pos;
        bit used [52];

        dec_tab[0]  = '{50, 12, 3, 10};
        dec_tab[1]  = '{13,  1, 1,  1};
        dec_tab[2]  = '{ 0,  1, 0,  1};
        dec_tab[3]  = '{12, 13, 0, 10};
        dec_tab[4]  = '{51, 13, 3, 10};
        dec_tab[5]  = '{ 9, 10, 0, 10};
        dec_tab[6]  = '{10, 11, 0, 10};
        dec_tab[7]  = '{26,  1, 2,  1};
        dec_tab[8]  = '{38, 13, 2, 10};
        dec_tab[9]  = '{22, 10, 1, 10};
        dec_tab[10] = '{35, 10, 2, 10};

        bus.load_flag = 1'b0;
        bus.card_in   = 6'd0;
        bus.deal_req  = 1'b0;
        rst_n         = 1'b1;
        #2;
        do_reset("por");
        tick();
        check("idle_shuffle", 32'(bus.shuffle_flag), 1);
        bus.deal_req = 1'b1;
        tick();
        bus.deal_req = 1'b0;
        check("shuf_deal_err", 32'(bus.deal_err), 1);
        check("shuf_deal_valid", 32'(bus.deal_valid), 0);
        tick();
        check("shuf_deal_err_pulse", 32'(bus.deal_err), 0);

        // Load 51..0 (load_flag dropped mid-load), then exhaust back-to-back.
        for (int i = 0; i < 52; i++) perm[i] = 51 - i;
        full_load("desc", 1'b1);
        bus.deal_req = 1'b1;
        for (int i = 1; i <= 52; i++) begin
            tick();
            check($sformatf("ex%0d_valid", i), 32'(bus.deal_valid), 1);
            check($sformatf("ex%0d_card", i), 32'(bus.deal_card), 52 - i);
            check($sformatf("ex%0d_rank", i), 32'(bus.deal_rank), ((52 - i) % 13) + 1);
            check($sformatf("ex%0d_left", i), 32'(bus.cards_left), 52 - i);
            check($sformatf("ex%0d_low", i), 32'(bus.low_deck), 32'(i >= 37 && i < 52));
        end
        check("ex_shuffle", 32'(bus.shuffle_flag), 1);
        check("ex_ready", 32'(bus.deck_ready), 0);
        tick();
        bus.deal_req = 1'b0;
        check("ex53_valid", 32'(bus.deal_valid), 0);
        check("ex53_err", 32'(bus.deal_err), 1);
        check("ex53_card_hold", 32'(bus.deal_card), 0);
        check("ex53_rank_hold", 32'(bus.deal_rank), 1);
        tick();
        check("ex53_err_pulse", 32'(bus.deal_err), 0);
        check("ex53_shuffle", 32'(bus.shuffle_flag), 1);

        // Decode table: table cards first, remaining cards ascending.
        for (int i = 0; i < 52; i++) used[i] = 1'b0;
        for (int i = 0; i < 11; i++) begin
            perm[i] = dec_tab[i].card;
            used[dec_tab[i].card] = 1'b1;
        end
        pos = 11;
        for (int c = 0; c < 52; c++) if (!used[c]) begin perm[pos] = c; pos++; end
        full_load("dec", 1'b0);
        for (int i = 0; i < 11; i++) begin
            bus.deal_req = 1'b1;
            tick();
            bus.deal_req = 1'b0;
            check($sformatf("dec%0d_valid", i), 32'(bus.deal_valid), 1);
            check($sformatf("dec%0d_card", i), 32'(bus.deal_card), dec_tab[i].card);
            check($sformatf("dec%0d_rank", i), 32'(bus.deal_rank), dec_tab[i].rank);
            check($sformatf("dec%0d_suit", i), 32'(bus.deal_suit), dec_tab[i].suit);
            check($sformatf("dec%0d_value", i), 32'(bus.deal_value), dec_tab[i].value);
            check($sformatf("dec%0d_left", i), 32'(bus.cards_left), 51 - i);
            tick();
            check($sformatf("dec%0d_idle_valid", i), 32'(bus.deal_valid), 0);
            check($sformatf("dec%0d_hold_card", i), 32'(bus.deal_card), dec_tab[i].card);
            check($sformatf("dec%0d_hold_rank", i), 32'(bus.deal_rank), dec_tab[i].rank);
        end
        do_reset("middeal");

        // Duplicate card 7 at slot 5 (first seen at slot 2).
        for (int i = 0; i < 52; i++) perm[i] = i;
        perm[1] = 7;
        perm[4] = 7;
        start_load();
        load_edges(0, 21, 1'b0);
        check("dup_err_before", 32'(bus.load_err), 0);
        load_edges(22, 22, 1'b0);
        check("dup_load_err", 32'(bus.load_err), 1);
        check("dup_ready", 32'(bus.deck_ready), 0);
        check("dup_shuffle", 32'(bus.shuffle_flag), 0);
        load_edges(23, 60, 1'b0);
        bus.load_flag = 1'b1;
        bus.deal_req  = 1'b1;
        tick();
        bus.deal_req  = 1'b0;
        check("err_deal_err", 32'(bus.deal_err), 1);
        check("err_deal_valid", 32'(bus.deal_valid), 0);
        tick();
        tick();
        check("err_sticky", 32'(bus.load_err), 1);
        check("err_stays", 32'(bus.shuffle_flag), 0);
        do_reset("dup");

        // Out-of-range card at slot 3.
        for (int i = 0; i < 52; i++) perm[i] = i;
        perm[2] = 60;
        start_load();
        load_edges(0, 13, 1'b0);
        check("oor_err_before", 32'(bus.load_err), 0);
        load_edges(14, 14, 1'b0);
        check("oor_load_err", 32'(bus.load_err), 1);
        check("oor_ready", 32'(bus.deck_ready), 0);
        do_reset("oor");

        // Reset at cycle 100 of a load, then reload and deal randomly.
        shuffle_perm();
        start_load();
        load_edges(0, 100, 1'b0);
        do_reset("midload");
        full_load("reload", 1'b0);
        random_deal(0);
        for (int r = 1; r <= 2; r++) begin
            shuffle_perm();
            full_load($sformatf("rnd%0d", r), 1'b0);
            random_deal(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/deck_receiver.md
DECK_RECEIVER -- requirements
Module: deck_receiver

Interface
REQ-001 SHALL have parameter DECK_SIZE, 52, number of cards per deck.
REQ-002 SHALL have parameter SLOT_CYCLES, 4, clocks per card on the load interface.
REQ-003 SHALL have parameter SAMPLE_PHASE, 2, cycle within a slot at which card_in is sampled.
REQ-004 SHALL have parameter LOW_WATER, 15, cards_left value at or below which low_deck asserts.
REQ-005 Ports SHALL be: clk input 1, the single clock; rst_n input 1, reset, asynchronous and active-low.
REQ-006 load_flag input 1: shuffler is loading.
REQ-007 card_in input 6: card index 0..51, updated once per slot.
REQ-008 shuffle_flag output 1: requests a shuffle from the shuffler.
REQ-009 deal_req input 1: one-cycle pulse requesting one card.
REQ-010 deal_valid output 1, deal_card output 6, deal_rank output 4 (1..13), deal_suit output 2, deal_value output 4 (blackjack points, ace=1).
REQ-011 deck_ready output 1, cards_left output 6, low_deck output 1, deal_err output 1, load_err output 1.

Function
REQ-012 SHALL implement FSM states SHUF, LOAD, READY and ERR.
REQ-013 SHUF SHALL drive shuffle_flag=1; all other states SHALL drive 0.
REQ-014 SHUF SHALL move to LOAD on the first clk edge where load_flag=1; that edge is slot cycle 0.
REQ-015 In LOAD, a cycle counter SHALL run from that edge; card_in SHALL be sampled at cycles SLOT_CYCLES*k+SAMPLE_PHASE for k=1..DECK_SIZE (cycles 6, 10, ..., 210).
REQ-016 Sampled card k SHALL be written to internal deck RAM entry k-1.
REQ-017 Each sample SHALL set a 52-bit seen bitmap; a sample with card_in>51 or an already-set bit SHALL assert load_err (sticky) and enter ERR.
REQ-018 After the 52nd valid sample, LOAD SHALL move to READY with cards_left=52, deck_ready=1 and read pointer=0.
REQ-019 load_flag dropping during LOAD SHALL be ignored.
REQ-020 In READY, deal_req with cards_left>0 SHALL produce deal_valid=1 exactly one cycle later, presenting RAM[pointer] and its decode; pointer SHALL increment and cards_left SHALL decrement.
REQ-021 deal_req on consecutive cycles SHALL each be honoured, giving back-to-back deal_valid.
REQ-022 deal_req with cards_left=0, or in any state other than READY, SHALL pulse deal_err for one cycle one cycle later, with no deal_valid and no state change.
REQ-023 When the last card is dealt (cards_left reaches 0), the FSM SHALL return to SHUF and deck_ready SHALL clear.
REQ-024 deal_rank SHALL equal (card mod 13)+1; deal_suit SHALL equal card div 13; deal_value SHALL be rank for ranks 1..10 and 10 for ranks 11..13.
REQ-025 low_deck SHALL equal deck_ready AND cards_left<=LOW_WATER.
REQ-026 ERR SHALL be left only by reset.
REQ-027 deal_card, deal_rank, deal_suit and deal_value SHALL hold their last value when deal_valid=0.

Reset
REQ-028 rst_n low SHALL immediately force: state SHUF (shuffle_flag=1), deal_valid=0, deal_card=0, deal_rank=0, deal_suit=0, deal_value=0, deck_ready=0, cards_left=0, low_deck=0, deal_err=0, load_err=0, seen bitmap cleared, counters and pointer 0.
REQ-029 Deck RAM contents SHALL NOT require reset.
REQ-030 Reset asserted mid-LOAD or mid-deal SHALL discard all partial progress.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, DECK_SIZE, SUIT_SIZE=13 and card/rank/suit widths.
REQ-032 Rank, suit and value decode SHALL be a separate combinational sub-module, card_decode.

Verification
REQ-033 Reset-then-load test: drive a slot-accurate model sending the permutation 51..0 -> at cycle 210 deck_ready=1, cards_left=52, shuffle_flag=0.
REQ-034 Decode test: deal with RAM[0]=50 -> deal_valid next cycle, deal_card=50, rank=12, suit=3, value=10; a card of 13 -> rank=1, suit=1, value=1.
REQ-035 Exhaustion test: 52 back-to-back deal_req -> 52 consecutive deal_valid, low_deck rising after the 37th deal, state SHUF after the last; a 53rd deal_req -> deal_err pulse only.
REQ-036 Duplicate test: model repeats card 7 at slot 5 -> load_err=1, state ERR, deck_ready=0; later deal_req -> deal_err.
REQ-037 Reset at cycle 100 of LOAD -> all outputs at reset values; a reload after release completes normally.
